// File: rtl/pwd_search_engine.sv
// pwd_search_engine: brute-force keyspace walker feeding one SHA-1 core.
// Latency: at least 3 cycles per candidate (ISSUE, WAIT, CHECK) plus the hash-core latency.
// Backpressure: msg_block is held stable while hash_req_valid waits for hash_req_ready;
// there is no timeout on the digest response.
//
// Candidates are PWD_LEN symbols over a RADIX alphabet ('0'-'9', 'a'-'z').
// The most-significant symbol is limited to [from_sym, to_sym] so that several
// engines can split one keyspace.
// Each candidate is sent to the hash core as a single SHA-1 padded 512-bit block.
// Each digest that comes back is compared with target_hash.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  pulse: latch range/target and begin (ignored while busy)
//   from_sym, to_sym       inclusive range of the most-significant symbol
//   target_hash            digest to search for
//   hash_req_valid/ready   request handshake carrying msg_block
//   hash_rsp_valid/digest  one-cycle digest return from the hash core
//   busy, done, found      search status; found is valid while done=1
//   range_err              the last start carried an illegal range
//   found_pwd              matching candidate in ASCII, first char in the MSBs
//   tried_count            digests compared; only counts when PWD_SEARCH_STATS_EN
//                          is defined, otherwise tied to 0
module pwd_search_engine #(
  parameter int PWD_LEN = 4,
  parameter int RADIX   = 36,
  parameter int SYM_W   = 6,
  parameter int HASH_W  = 160,
  parameter int CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [SYM_W-1:0]     from_sym,
  input  logic [SYM_W-1:0]     to_sym,
  input  logic [HASH_W-1:0]    target_hash,
  output logic                 hash_req_valid,
  input  logic                 hash_req_ready,
  output logic [511:0]         msg_block,
  input  logic                 hash_rsp_valid,
  input  logic [HASH_W-1:0]    hash_rsp_digest,
  output logic                 busy,
  output logic                 done,
  output logic                 found,
  output logic                 range_err,
  output logic [8*PWD_LEN-1:0] found_pwd,
  output logic [CNT_W-1:0]     tried_count
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, FIN} state_t;

  localparam logic [SYM_W-1:0] SYM_MAX = SYM_W'(RADIX - 1);
  localparam logic [SYM_W-1:0] RADIX_S = SYM_W'(RADIX);

  state_t               state;
  logic [SYM_W-1:0]     sym     [PWD_LEN];  // sym[0] is the most significant symbol
  logic [SYM_W-1:0]     sym_inc [PWD_LEN];
  logic [SYM_W-1:0]     to_r;
  logic [HASH_W-1:0]    target_r;
  logic [HASH_W-1:0]    dig_r;
  logic                 range_bad;
  logic                 is_last;
  logic                 carry;
  logic [511:0]         blk_start;
  logic [511:0]         blk_inc;
  logic [8*PWD_LEN-1:0] cur_text;

  function automatic logic [7:0] to_ascii(input logic [SYM_W-1:0] s);
    if (s < SYM_W'(10)) return 8'd48 + 8'(s);
    else                return 8'd87 + 8'(s);  // 10 -> 'a' (0x61)
  endfunction

  assign range_bad = (from_sym > to_sym) || (to_sym >= RADIX_S);

  // Odometer increment: the least significant symbol is sym[PWD_LEN-1].
  always_comb begin
    sym_inc = sym;
    carry   = 1'b1;
    for (int i = PWD_LEN - 1; i >= 0; i--) begin
      if (carry) begin
        if (sym[i] == SYM_MAX) begin
          sym_inc[i] = '0;
        end else begin
          sym_inc[i] = sym[i] + SYM_W'(1);
          carry      = 1'b0;
        end
      end
    end
  end

  // The last candidate is detected by equality.
  // A <= compare would let to_sym = 2^SYM_W-1 wrap around and loop forever.
  always_comb begin
    is_last = (sym[0] == to_r);
    for (int i = 1; i < PWD_LEN; i++) begin
      if (sym[i] != SYM_MAX) is_last = 1'b0;
    end
  end

  // Padded blocks for the two places a new candidate is loaded.
  // The first is the range start; the second is the incremented candidate.
  always_comb begin
    blk_start = '0;
    blk_inc   = '0;
    cur_text  = '0;
    for (int i = 0; i < PWD_LEN; i++) begin
      blk_start[511-8*i -: 8]           = to_ascii((i == 0) ? from_sym : '0);
      blk_inc[511-8*i -: 8]             = to_ascii(sym_inc[i]);
      cur_text[8*(PWD_LEN-i)-1 -: 8]    = to_ascii(sym[i]);
    end
    blk_start[511-8*PWD_LEN -: 8] = 8'h80;
    blk_inc[511-8*PWD_LEN -: 8]   = 8'h80;
    blk_start[63:0]               = 64'(8 * PWD_LEN);
    blk_inc[63:0]                 = 64'(8 * PWD_LEN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      found          <= 1'b0;
      range_err      <= 1'b0;
      hash_req_valid <= 1'b0;
      found_pwd      <= '0;
      msg_block      <= '0;
      to_r           <= '0;
      target_r       <= '0;
      dig_r          <= '0;
      for (int i = 0; i < PWD_LEN; i++) sym[i] <= '0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (start) begin
            to_r     <= to_sym;
            target_r <= target_hash;
            found    <= 1'b0;
            if (range_bad) begin
              range_err <= 1'b1;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= FIN;
            end else begin
              range_err      <= 1'b0;
              done           <= 1'b0;
              busy           <= 1'b1;
              for (int i = 0; i < PWD_LEN; i++) sym[i] <= (i == 0) ? from_sym : '0;
              msg_block      <= blk_start;
              hash_req_valid <= 1'b1;
              state          <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (hash_req_ready) begin
            hash_req_valid <= 1'b0;
            state          <= WAIT;
          end
        end
        WAIT: begin
          if (hash_rsp_valid) begin
            dig_r <= hash_rsp_digest;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (dig_r == target_r) begin
            found     <= 1'b1;
            found_pwd <= cur_text;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= FIN;
          end else if (is_last) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FIN;
          end else begin
            sym            <= sym_inc;
            msg_block      <= blk_inc;
            hash_req_valid <= 1'b1;
            state          <= ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PWD_SEARCH_STATS_EN
  // Counts compared digests and saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tried_count <= '0;
    end else if ((state == IDLE || state == FIN) && start) begin
      tried_count <= '0;
    end else if (state == CHECK && tried_count != '1) begin
      tried_count <= tried_count + CNT_W'(1);
    end
  end
`else
  assign tried_count = '0;
`endif

endmodule

// File: tb/tb_pwd_search_engine.sv
module tb_pwd_search_engine;

  localparam int LAT = 5;

  logic         clk;
  logic         rst_n;

  // main engine: PWD_LEN=4, RADIX=36
  logic         start;
  logic [5:0]   from_sym, to_sym;
  logic [159:0] target_hash;
  logic         hash_req_valid, hash_req_ready;
  logic [511:0] msg_block;
  logic         hash_rsp_valid;
  logic [159:0] hash_rsp_digest;
  logic         busy, done, found, range_err;
  logic [31:0]  found_pwd;
  logic [31:0]  tried_count;

  // short engine: PWD_LEN=3, RADIX=36; a full wrap with it stays within the cycle budget
  logic         s_start;
  logic [5:0]   s_from, s_to;
  logic [159:0] s_target;
  logic         s_req_valid, s_req_ready;
  logic [511:0] s_msg;
  logic         s_rsp_valid;
  logic [159:0] s_rsp_digest;
  logic         s_busy, s_done, s_found, s_range_err;
  logic [23:0]  s_found_pwd;
  logic [31:0]  s_tried;

  int n_tests = 0;
  int n_fail  = 0;

  pwd_search_engine #(.PWD_LEN(4), .RADIX(36), .SYM_W(6), .HASH_W(160), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .from_sym(from_sym), .to_sym(to_sym),
    .target_hash(target_hash), .hash_req_valid(hash_req_valid), .hash_req_ready(hash_req_ready),
    .msg_block(msg_block), .hash_rsp_valid(hash_rsp_valid), .hash_rsp_digest(hash_rsp_digest),
    .busy(busy), .done(done), .found(found), .range_err(range_err),
    .found_pwd(found_pwd), .tried_count(tried_count)
  );

  pwd_search_engine #(.PWD_LEN(3), .RADIX(36), .SYM_W(6), .HASH_W(160), .CNT_W(32)) u_short (
    .clk(clk), .rst_n(rst_n), .start(s_start), .from_sym(s_from), .to_sym(s_to),
    .target_hash(s_target), .hash_req_valid(s_req_valid), .hash_req_ready(s_req_ready),
    .msg_block(s_msg), .hash_rsp_valid(s_rsp_valid), .hash_rsp_digest(s_rsp_digest),
    .busy(s_busy), .done(s_done), .found(s_found), .range_err(s_range_err),
    .found_pwd(s_found_pwd), .tried_count(s_tried)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [159:0] sha1_block(input logic [511:0] blk);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, tmp;
    logic [31:0] h0, h1, h2, h3, h4;
    h0 = 32'h67452301; h1 = 32'hEFCDAB89; h2 = 32'h98BADCFE;
    h3 = 32'h10325476; h4 = 32'hC3D2E1F0;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 80; t++) begin
      tmp  = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
      w[t] = {tmp[30:0], tmp[31]};
    end
    a = h0; b = h1; c = h2; d = h3; e = h4;
    for (int t = 0; t < 80; t++) begin
      if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
      else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
      else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
    end
    return {h0 + a, h1 + b, h2 + c, h3 + d, h4 + e};
  endfunction

  function automatic byte sym_char(input int d);
    return (d < 10) ? 8'(48 + d) : 8'(87 + d);
  endfunction

  // idx-th candidate of a search whose first symbol starts at f (radix 36)
  function automatic string cand_text(input int f, input int idx, input int len);
    string s;
    int    r;
    s = "";
    r = idx;
    for (int j = len - 1; j >= 1; j--) begin
      s = $sformatf("%c%s", sym_char(r % 36), s);
      r = r / 36;
    end
    s = $sformatf("%c%s", sym_char(f + r), s);
    return s;
  endfunction

  function automatic logic [511:0] pack_string(input string s);
    logic [511:0] b;
    b = '0;
    for (int i = 0; i < s.len(); i++) b[511-8*i -: 8] = s.getc(i);
    b[511-8*s.len() -: 8] = 8'h80;
    b[63:0] = 64'(8 * s.len());
    return b;
  endfunction

  function automatic logic [31:0] str32(input string s);
    return {s.getc(0), s.getc(1), s.getc(2), s.getc(3)};
  endfunction

  function automatic int exp_tried(input int n);
`ifdef PWD_SEARCH_STATS_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  // ---------------- hash core models ----------------
  typedef struct { int due; logic [159:0] dig; } rsp_t;
  rsp_t         pend[$];
  rsp_t         s_pend[$];
  logic [511:0] log_q[$];
  int           cyc = 0;
  int           bp_mode = 0;   // 0: always ready, 1: 7-cycle stall, 2: random
  int           stall = 0;
  int           unstable = 0;
  bit           have_prev = 0;
  logic [511:0] prev_blk = '0;
  int           s_cnt = 0;

  initial begin
    hash_req_ready = 1'b1; hash_rsp_valid = 1'b0; hash_rsp_digest = '0;
    s_req_ready = 1'b1;    s_rsp_valid = 1'b0;    s_rsp_digest = '0;
  end

  // Deliberately blind to rst_n so that a response in flight across a reset
  // still arrives afterwards.
  always @(negedge clk) begin
    rsp_t r;
    cyc++;
    hash_rsp_valid = 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      hash_rsp_valid  = 1'b1;
      hash_rsp_digest = pend[0].dig;
      pend.delete(0);
    end
    if (hash_req_valid) begin
      if (bp_mode == 1) begin
        if (stall < 7) begin hash_req_ready = 1'b0; stall++; end
        else begin hash_req_ready = 1'b1; stall = 0; end
      end else if (bp_mode == 2) begin
        hash_req_ready = ($urandom_range(0, 2) == 0);
      end else begin
        hash_req_ready = 1'b1;
      end
      if (have_prev && msg_block !== prev_blk) unstable++;
      if (hash_req_ready) begin
        have_prev = 0;
        log_q.push_back(msg_block);
        r.due = cyc + LAT;
        r.dig = sha1_block(msg_block);
        pend.push_back(r);
      end else begin
        prev_blk  = msg_block;
        have_prev = 1;
      end
    end else begin
      hash_req_ready = (bp_mode == 0);
      stall     = 0;
      have_prev = 0;
    end
  end

  always @(negedge clk) begin
    rsp_t r;
    s_rsp_valid = 1'b0;
    if (s_pend.size() > 0 && s_pend[0].due <= cyc) begin
      s_rsp_valid  = 1'b1;
      s_rsp_digest = s_pend[0].dig;
      s_pend.delete(0);
    end
    if (s_req_valid) begin
      s_cnt++;
      r.due = cyc + LAT;
      r.dig = sha1_block(s_msg);
      s_pend.push_back(r);
    end
  end

  // number of logged requests that disagree with the expected enumeration
  function automatic int log_errs(input int f, input int n);
    int e;
    e = (log_q.size() != n) ? 1 : 0;
    for (int i = 0; i < log_q.size() && i < n; i++)
      if (log_q[i] !== pack_string(cand_text(f, i, 4))) e++;
    return e;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic start_main(input logic [5:0] f, input logic [5:0] t, input logic [159:0] tg);
    @(negedge clk);
    from_sym = f; to_sym = t; target_hash = tg; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done_main(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    n_tests++;
    if ({busy, done, found, range_err, hash_req_valid} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000", {busy, done, found, range_err, hash_req_valid});
    end
    n_tests++;
    if (found_pwd !== 32'h0) begin n_fail++; $display("FAIL reset_found_pwd: got %h expected 0", found_pwd); end
    n_tests++;
    if (msg_block !== 512'h0) begin n_fail++; $display("FAIL reset_msg_block: got %h expected 0", msg_block); end
    n_tests++;
    if (tried_count !== 32'h0) begin n_fail++; $display("FAIL reset_tried: got %0d expected 0", tried_count); end
  endtask

  task automatic test_hit;
    bit ok;
    int e;
    log_q.delete(); bp_mode = 0;
    start_main(6'd0, 6'd0, sha1_block(pack_string("00a3")));
    wait_done_main(6000, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL hit_timeout: done never rose within 6000 cycles"); end
    n_tests++;
    if ({done, found, busy} !== 3'b110) begin n_fail++; $display("FAIL hit_flags: got %b expected 110", {done, found, busy}); end
    n_tests++;
    if (found_pwd !== 32'h30306133) begin n_fail++; $display("FAIL hit_pwd: got %h expected 30306133", found_pwd); end
    n_tests++;
    if (tried_count !== 32'(exp_tried(364))) begin
      n_fail++; $display("FAIL hit_tried: got %0d expected %0d", tried_count, exp_tried(364));
    end
    e = log_errs(0, 364);
    n_tests++;
    if (e != 0) begin n_fail++; $display("FAIL hit_log: %0d bad entries, %0d logged, expected 364", e, log_q.size()); end
  endtask

  task automatic test_illegal;
    logic [5:0] fs [3];
    logic [5:0] ts [3];
    int viol;
    fs[0] = 6'd5; ts[0] = 6'd3;
    fs[1] = 6'd0; ts[1] = 6'd36;
    fs[2] = 6'($urandom_range(0, 63)); ts[2] = 6'($urandom_range(36, 63));
    for (int c = 0; c < 3; c++) begin
      log_q.delete();
      start_main(fs[c], ts[c], 160'h0);
      n_tests++;
      if ({range_err, done, found, busy} !== 4'b1100) begin
        n_fail++; $display("FAIL illegal_flags[%0d]: got %b expected 1100", c, {range_err, done, found, busy});
      end
      viol = 0;
      for (int i = 0; i < 4; i++) begin
        if (hash_req_valid !== 1'b0) viol++;
        @(negedge clk);
      end
      n_tests++;
      if (viol != 0 || log_q.size() != 0) begin
        n_fail++; $display("FAIL illegal_noreq[%0d]: valid seen %0d times, %0d requests, expected none", c, viol, log_q.size());
      end
      n_tests++;
      if (range_err !== 1'b1 || done !== 1'b1) begin
        n_fail++; $display("FAIL illegal_hold[%0d]: got range_err=%b done=%b expected 1 1", c, range_err, done);
      end
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    int e;
    log_q.delete(); bp_mode = 1; unstable = 0;
    start_main(6'd0, 6'd0, sha1_block(pack_string("00a3")));
    wait_done_main(10000, ok);
    bp_mode = 0;
    n_tests++;
    if (!ok || found !== 1'b1 || found_pwd !== 32'h30306133) begin
      n_fail++; $display("FAIL bp_result: done=%b found=%b pwd=%h expected 1 1 30306133", done, found, found_pwd);
    end
    n_tests++;
    if (tried_count !== 32'(exp_tried(364))) begin
      n_fail++; $display("FAIL bp_tried: got %0d expected %0d", tried_count, exp_tried(364));
    end
    n_tests++;
    if (unstable != 0) begin n_fail++; $display("FAIL bp_stable: msg_block changed %0d times while stalled, expected 0", unstable); end
    e = log_errs(0, 364);
    n_tests++;
    if (e != 0) begin n_fail++; $display("FAIL bp_log: %0d bad entries, %0d logged, expected 364", e, log_q.size()); end
  endtask

  task automatic test_random;
    bit    ok;
    int    f, t, idx, e;
    string s;
    for (int it = 0; it < 3; it++) begin
      f   = int'($urandom_range(0, 35));
      t   = int'($urandom_range(f, 35));
      idx = int'($urandom_range(0, 250));
      s   = cand_text(f, idx, 4);
      log_q.delete(); bp_mode = 2;
      start_main(6'(f), 6'(t), sha1_block(pack_string(s)));
      wait_done_main(20 * (idx + 1) + 100, ok);
      bp_mode = 0;
      n_tests++;
      if (!ok || found !== 1'b1) begin
        n_fail++; $display("FAIL rand_found[%0d]: done=%b found=%b expected 1 1 (from=%0d idx=%0d)", it, done, found, f, idx);
      end
      n_tests++;
      if (found_pwd !== str32(s)) begin
        n_fail++; $display("FAIL rand_pwd[%0d]: got %h expected %h", it, found_pwd, str32(s));
      end
      n_tests++;
      if (tried_count !== 32'(exp_tried(idx + 1))) begin
        n_fail++; $display("FAIL rand_tried[%0d]: got %0d expected %0d", it, tried_count, exp_tried(idx + 1));
      end
      e = log_errs(f, idx + 1);
      n_tests++;
      if (e != 0) begin n_fail++; $display("FAIL rand_log[%0d]: %0d bad entries, %0d logged, expected %0d", it, e, log_q.size(), idx + 1); end
    end
  endtask

  task automatic test_full_wrap;
    bit ok;
    s_cnt = 0;
    @(negedge clk);
    s_from = 6'd0; s_to = 6'd0; s_target = sha1_block(pack_string("zzz")); s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    ok = 0;
    for (int i = 0; i < 30000; i++) begin
      if (s_done === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    n_tests++;
    if (!ok || s_found !== 1'b0 || s_busy !== 1'b0) begin
      n_fail++; $display("FAIL wrap_result: done=%b found=%b busy=%b expected 1 0 0", s_done, s_found, s_busy);
    end
    n_tests++;
    if (s_cnt != 1296) begin n_fail++; $display("FAIL wrap_count: got %0d requests expected 1296", s_cnt); end
    n_tests++;
    if (s_tried !== 32'(exp_tried(1296))) begin
      n_fail++; $display("FAIL wrap_tried: got %0d expected %0d", s_tried, exp_tried(1296));
    end
    n_tests++;
    if (s_msg !== pack_string("0zz")) begin n_fail++; $display("FAIL wrap_last_block: got %h expected %h", s_msg, pack_string("0zz")); end
    n_tests++;
    if (s_msg[487:480] !== 8'h80 || s_msg[63:0] !== 64'h18) begin
      n_fail++; $display("FAIL wrap_padding: got pad=%h len=%h expected 80 18", s_msg[487:480], s_msg[63:0]);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    log_q.delete(); bp_mode = 0;
    start_main(6'd0, 6'd0, sha1_block(pack_string("00a3")));
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pend.size() > 0) begin ok = 1; break; end
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL rmid_req: no request within 50 cycles"); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, found, range_err, hash_req_valid} !== 5'b0 || msg_block !== 512'h0 ||
        found_pwd !== 32'h0 || tried_count !== 32'h0) begin
      n_fail++; $display("FAIL rmid_async: flags=%b pwd=%h tried=%0d expected all zero",
                         {busy, done, found, range_err, hash_req_valid}, found_pwd, tried_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (pend.size() == 0) begin ok = 1; break; end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (!ok || {busy, done, found, range_err, hash_req_valid} !== 5'b0) begin
      n_fail++; $display("FAIL rmid_stray: flags=%b expected 00000 after stray response", {busy, done, found, range_err, hash_req_valid});
    end
    log_q.delete();
    start_main(6'd35, 6'd35, sha1_block(pack_string("z000")));
    wait_done_main(100, ok);
    n_tests++;
    if (!ok || found !== 1'b1 || found_pwd !== 32'h7a303030) begin
      n_fail++; $display("FAIL rmid_restart: done=%b found=%b pwd=%h expected 1 1 7a303030", done, found, found_pwd);
    end
    n_tests++;
    if (tried_count !== 32'(exp_tried(1)) || log_q.size() != 1) begin
      n_fail++; $display("FAIL rmid_tried: got %0d (%0d requests) expected %0d (1 request)", tried_count, log_q.size(), exp_tried(1));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; from_sym = '0; to_sym = '0; target_hash = '0;
    s_start = 1'b0; s_from = '0; s_to = '0; s_target = '0;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_reset;
    test_hit;
    test_illegal;
    test_backpressure;
    test_random;
    test_full_wrap;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

endmodule
